// File: rtl/img_inv_pkg.sv
// Shared types and defaults for the UART image-inversion sequencer.
// The CK_SEND/CK_WAIT states are only reachable with IMG_INV_CHECKSUM_EN defined.
package img_inv_pkg;

   localparam int FRAME_BYTES_DEF = 158;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      RX_FILL,
      TX_LOAD,
      TX_SEND,
      TX_WAIT,
      DONE,
      CK_SEND,
      CK_WAIT
   } state_t;

endpackage

// File: rtl/img_frame_buf.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module img_frame_buf
   import img_inv_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  byte_t             wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output byte_t             rdata
);

   byte_t mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/img_inv_stream_ctrl.sv
// Captures one fixed-length frame from UART rx, then replays it (optionally inverted)
// to UART tx paced by i_tx_done. Optional trailing XOR checksum: IMG_INV_CHECKSUM_EN.
module img_inv_stream_ctrl
   import img_inv_pkg::*;
#(
   parameter int FRAME_BYTES = FRAME_BYTES_DEF,
   parameter int ADDR_W      = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset_rtl,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_data_valid,
   input  logic             i_invert_en,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_data_valid,
   input  logic             i_tx_done,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_overrun,
   output logic [CNT_W-1:0] o_frame_count,
   output logic [2:0]       o_dbg_state
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              inv_q;
   byte_t             rdata, tx_byte;
   logic              buf_we, buf_re, frame_start;
   logic [ADDR_W-1:0] buf_waddr;
`ifdef IMG_INV_CHECKSUM_EN
   byte_t             csum;
`endif

   img_frame_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clock (clock),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (i_rx_data),
      .re    (buf_re),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign tx_byte     = inv_q ? ~rdata : rdata;
   assign o_busy      = (state != IDLE);
   assign o_dbg_state = state;

   always_comb begin
      state_next  = state;
      buf_we      = 1'b0;
      buf_waddr   = wr_ptr;
      buf_re      = 1'b0;
      frame_start = 1'b0;
      case (state)
         IDLE: if (i_rx_data_valid) begin
            buf_we      = 1'b1;
            buf_waddr   = '0;
            frame_start = 1'b1;
            state_next  = RX_FILL;
         end
         RX_FILL: if (i_rx_data_valid) begin
            buf_we = 1'b1;
            if (wr_ptr == LAST) state_next = TX_LOAD;
         end
         TX_LOAD: begin
            buf_re     = 1'b1;
            state_next = TX_SEND;
         end
         TX_SEND: state_next = TX_WAIT;
         TX_WAIT: if (i_tx_done) begin
`ifdef IMG_INV_CHECKSUM_EN
            state_next = (rd_ptr == LAST) ? CK_SEND : TX_LOAD;
`else
            state_next = (rd_ptr == LAST) ? DONE : TX_LOAD;
`endif
         end
`ifdef IMG_INV_CHECKSUM_EN
         CK_SEND: state_next = CK_WAIT;
         CK_WAIT: if (i_tx_done) state_next = DONE;
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_rtl) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         inv_q           <= 1'b0;
         o_tx_data       <= '0;
         o_tx_data_valid <= 1'b0;
         o_frame_done    <= 1'b0;
         o_overrun       <= 1'b0;
         o_frame_count   <= '0;
`ifdef IMG_INV_CHECKSUM_EN
         csum            <= '0;
`endif
      end else begin
         state           <= state_next;
         o_tx_data_valid <= 1'b0;
         o_frame_done    <= 1'b0;

         // Invert setting is frozen at the first byte of the frame.
         if (frame_start) begin
            inv_q  <= i_invert_en;
            wr_ptr <= ADDR_W'(1);
`ifdef IMG_INV_CHECKSUM_EN
            csum   <= '0;
`endif
         end else if (state == RX_FILL && i_rx_data_valid) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end

         if (state == RX_FILL && state_next == TX_LOAD) rd_ptr <= '0;
         if (state == TX_WAIT && state_next == TX_LOAD) rd_ptr <= rd_ptr + ADDR_W'(1);

         if (state == TX_SEND) begin
            o_tx_data       <= tx_byte;
            o_tx_data_valid <= 1'b1;
`ifdef IMG_INV_CHECKSUM_EN
            csum            <= csum ^ tx_byte;
`endif
         end
`ifdef IMG_INV_CHECKSUM_EN
         if (state == CK_SEND) begin
            o_tx_data       <= csum;
            o_tx_data_valid <= 1'b1;
         end
`endif

         // Frame done and count land together with the DONE state itself.
         if (state_next == DONE) begin
            o_frame_done  <= 1'b1;
            o_frame_count <= o_frame_count + CNT_W'(1);
         end

         if (i_rx_data_valid && state != IDLE && state != RX_FILL) o_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_img_inv_stream_ctrl.sv
// Self-checking bench for img_inv_stream_ctrl: randomized frames against a queue model.
// Checksum expectations follow IMG_INV_CHECKSUM_EN when defined.
module tb_img_inv_stream_ctrl;
   import img_inv_pkg::*;

   localparam int FB     = 158;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 16;

   logic             clock = 1'b0;
   logic             reset_rtl;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             invert_en;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_done;
   logic             busy;
   logic             frame_done;
   logic             overrun;
   logic [CNT_W-1:0] frame_count;
   logic [2:0]       dbg_state;

   img_inv_stream_ctrl #(.FRAME_BYTES(FB), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clock           (clock),
      .reset_rtl       (reset_rtl),
      .i_rx_data       (rx_data),
      .i_rx_data_valid (rx_valid),
      .i_invert_en     (invert_en),
      .o_tx_data       (tx_data),
      .o_tx_data_valid (tx_valid),
      .i_tx_done       (tx_done),
      .o_busy          (busy),
      .o_frame_done    (frame_done),
      .o_overrun       (overrun),
      .o_frame_count   (frame_count),
      .o_dbg_state     (dbg_state)
   );

   // clock / reset
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // scoreboard state
   int               err_cnt = 0;
   int               chk_cnt = 0;
   logic [7:0]       exp_q[$];
   logic [7:0]       frame_mem [FB];
   int               tx_idx = 0;
   int               frames_seen = 0;
   int               last_rx_cyc = 0;
   int               last_done_cyc = 0;
   int               last_valid_cyc = 0;
   logic             prev_valid = 1'b0;
   bit               hold_done = 1'b0;
   int               done_delay = 20;
   logic [CNT_W-1:0] exp_count = '0;
   logic             exp_overrun = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clock) begin
      if (reset_rtl) begin
         tx_idx     = 0;
         prev_valid = 1'b0;
      end else begin
         if (rx_valid) last_rx_cyc = cyc;
         if (tx_done && !hold_done) last_done_cyc = cyc;
         if (tx_valid) begin
            check("valid_width", {31'd0, prev_valid}, 0);
            if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
            else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            if (tx_idx == 0) check("rx_to_tx_latency", cyc - last_rx_cyc, 3);
            else if (tx_idx < FB) begin
               if (hold_done) check("valid_gap", cyc - last_valid_cyc, 3);
               else check("done_to_tx_latency", cyc - last_done_cyc, 3);
            end
            last_valid_cyc = cyc;
            tx_idx++;
         end
         if (frame_done) begin
            frames_seen++;
            tx_idx = 0;
         end
         prev_valid = tx_valid;
      end
   end

   // tx core responder: done pulse done_delay clocks after each valid, or held high
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clock);
         if (hold_done) tx_done = 1'b1;
         else begin
            tx_done = 1'b0;
            if (tx_valid) begin
               repeat (done_delay) @(posedge clock);
               #1 tx_done = 1'b1;
               @(posedge clock);
               #1 tx_done = 1'b0;
            end
         end
      end
   end

   // driver tasks; caller always sits just after a rising edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock); #1;
      rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic run_frame(input logic inv, input bit toggle, input bit inject, input int max_gap);
      logic [7:0] xs;
      logic [7:0] e;
      int         start;
      xs        = '0;
      invert_en = inv;
      for (int i = 0; i < FB; i++) begin
         e = inv ? ~frame_mem[i] : frame_mem[i];
         exp_q.push_back(e);
         xs = xs ^ e;
      end
`ifdef IMG_INV_CHECKSUM_EN
      exp_q.push_back(xs);
`endif
      start = frames_seen;
      for (int i = 0; i < FB; i++) begin
         if (toggle && i == FB / 2) invert_en = ~inv;
         send_byte(frame_mem[i], $urandom_range(0, max_gap));
      end
      if (inject) begin
         for (int k = 0; k < 2000 && tx_idx < 6; k++) begin
            @(posedge clock); #1;
         end
         check("overrun_window", (tx_idx >= 6) ? 1 : 0, 1);
         send_byte(8'hAA, 0);
         exp_overrun = 1'b1;
      end
      for (int k = 0; k < FB * 30 + 200 && frames_seen == start; k++) begin
         @(posedge clock); #1;
      end
      check("frame_done_seen", frames_seen - start, 1);
      repeat (5) begin
         @(posedge clock); #1;
      end
      check("frame_done_once", frames_seen - start, 1);
      exp_count = exp_count + CNT_W'(1);
      check("frame_count", {16'd0, frame_count}, {16'd0, exp_count});
      check("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
      check("busy_idle", {31'd0, busy}, 0);
      check("exp_q_empty", exp_q.size(), 0);
      exp_q.delete();
      invert_en = inv;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_tx_data"},  {24'd0, tx_data}, 0);
      check({tag, "_tx_valid"}, {31'd0, tx_valid}, 0);
      check({tag, "_busy"},     {31'd0, busy}, 0);
      check({tag, "_done"},     {31'd0, frame_done}, 0);
      check({tag, "_overrun"},  {31'd0, overrun}, 0);
      check({tag, "_count"},    {16'd0, frame_count}, 0);
      check({tag, "_state"},    {29'd0, dbg_state}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", err_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_rtl = 1'b1;
      rx_data   = '0;
      rx_valid  = 1'b0;
      invert_en = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_outputs_zero("reset");
      @(posedge clock); #1;
      reset_rtl = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
      end

      // counting pattern, inverted, done 20 clocks after each valid
      for (int i = 0; i < FB; i++) frame_mem[i] = 8'(i);
      done_delay = 20;
      run_frame(1'b1, 1'b0, 1'b0, 2);

      // pass-through with invert toggled mid-frame
      run_frame(1'b0, 1'b1, 1'b0, 2);

      // overrun injected while waiting on byte 5
      for (int i = 0; i < FB; i++) frame_mem[i] = 8'($urandom);
      run_frame(1'($urandom_range(0, 1)), 1'b0, 1'b1, 3);

      // reset part-way through reception abandons the frame
      invert_en = 1'b1;
      for (int i = 0; i < 80; i++) send_byte(8'($urandom), $urandom_range(0, 2));
      reset_rtl = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_outputs_zero("mid_reset");
      @(posedge clock); #1;
      reset_rtl   = 1'b0;
      exp_count   = '0;
      exp_overrun = 1'b0;
      repeat (10) begin
         @(posedge clock); #1;
      end
      check("busy_after_reset", {31'd0, busy}, 0);
      for (int i = 0; i < FB; i++) frame_mem[i] = 8'($urandom);
      done_delay = $urandom_range(1, 20);
      run_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0, 3);

      // tx_done held high
      for (int i = 0; i < FB; i++) frame_mem[i] = 8'($urandom);
      hold_done = 1'b1;
      run_frame(1'b1, 1'b0, 1'b0, 1);
      hold_done = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end

      // constant 0x0F frame, inverted
      for (int i = 0; i < FB; i++) frame_mem[i] = 8'h0F;
      done_delay = $urandom_range(1, 20);
      run_frame(1'b1, 1'b0, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
